// File: rtl/seven_seg_capture_pkg.sv
// Shared glyph constants and select-decode helper for the seven-segment capture block
// and the display driver that produces the multiplexed bus.
package seven_seg_capture_pkg;

  // Active-low .gfedcba glyphs with the dot segment dark.
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_DOT = 8'h7F;

  typedef enum logic [1:0] {
    SEL_BLANK,
    SEL_ONE,
    SEL_MULTI
  } sel_kind_t;

  typedef struct packed {
    sel_kind_t  kind;
    logic [1:0] index;
  } sel_info_t;

  function automatic sel_info_t decode_sel(input logic [3:0] sel);
    sel_info_t info;
    info.kind  = SEL_MULTI;
    info.index = 2'd0;
    case (sel)
      4'b1111: info.kind = SEL_BLANK;
      4'b1110: begin info.kind = SEL_ONE; info.index = 2'd0; end
      4'b1101: begin info.kind = SEL_ONE; info.index = 2'd1; end
      4'b1011: begin info.kind = SEL_ONE; info.index = 2'd2; end
      4'b0111: begin info.kind = SEL_ONE; info.index = 2'd3; end
      default: info.kind = SEL_MULTI;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Multiplexed display bus plus recovered-digit outputs; master drives the display,
// slave is the capture block.
interface seven_seg_capture_if;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic [3:0]  valid;
  logic        frame_done;
  logic        bad_seg;
  logic        bad_sel;

  modport master (
    output io_sel, io_seg,
    input  digits, dots, valid, frame_done, bad_seg, bad_sel
  );

  modport slave (
    input  io_sel, io_seg,
    output digits, dots, valid, frame_done, bad_seg, bad_sel
  );
endinterface

// File: rtl/seven_seg_capture_decode.sv
// Combinational glyph-to-nibble lookup; match is low for any pattern outside 0-9, A-F.
module seven_seg_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       match
);

  always_comb begin
    nibble = 4'h0;
    match  = 1'b1;
    case (seg)
      SEG_0[6:0]: nibble = 4'h0;
      SEG_1[6:0]: nibble = 4'h1;
      SEG_2[6:0]: nibble = 4'h2;
      SEG_3[6:0]: nibble = 4'h3;
      SEG_4[6:0]: nibble = 4'h4;
      SEG_5[6:0]: nibble = 4'h5;
      SEG_6[6:0]: nibble = 4'h6;
      SEG_7[6:0]: nibble = 4'h7;
      SEG_8[6:0]: nibble = 4'h8;
      SEG_9[6:0]: nibble = 4'h9;
      SEG_A[6:0]: nibble = 4'hA;
      SEG_B[6:0]: nibble = 4'hB;
      SEG_C[6:0]: nibble = 4'hC;
      SEG_D[6:0]: nibble = 4'hD;
      SEG_E[6:0]: nibble = 4'hE;
      SEG_F[6:0]: nibble = 4'hF;
      default:    match  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers four hex digits from a multiplexed active-low seven-segment bus by
// capturing each sel/seg observation once it has been stable for SETTLE cycles.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int SETTLE = 16,
  parameter int STALE  = 1048576
) (
  input logic               clk,
  input logic               rst,
  seven_seg_capture_if.slave bus
);

  localparam int AW = $clog2(STALE + 1);

  logic [3:0]    sel_meta, sel_sync, sel_prev;
  logic [7:0]    seg_meta, seg_sync, seg_prev;
  logic [7:0]    stable_cnt;
  logic [AW-1:0] age;
  logic [3:0]    mask;
  logic [15:0]   digits_q;
  logic [3:0]    dots_q, valid_q;
  logic          frame_q, bad_seg_q, bad_sel_q;
  logic          changed, capture, frame_fire, match;
  logic [3:0]    nibble;
  sel_info_t     sel_info;

  seven_seg_decode u_decode (
    .seg    (seg_sync[6:0]),
    .nibble (nibble),
    .match  (match)
  );

  // Capture fires on the edge where the counter steps to SETTLE-1, so it happens once per stable period.
  always_comb begin
    sel_info   = decode_sel(sel_sync);
    changed    = {sel_sync, seg_sync} != {sel_prev, seg_prev};
    capture    = !changed && (stable_cnt == 8'(SETTLE - 2));
    frame_fire = capture && (sel_info.kind == SEL_ONE) && match &&
                 (sel_info.index == 2'd0) && (mask[3:1] == 3'b111);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta   <= '1;
      sel_sync   <= '1;
      sel_prev   <= '1;
      seg_meta   <= '1;
      seg_sync   <= '1;
      seg_prev   <= '1;
      stable_cnt <= '0;
    end else begin
      sel_meta <= bus.io_sel;
      sel_sync <= sel_meta;
      sel_prev <= sel_sync;
      seg_meta <= bus.io_seg;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      if (changed)
        stable_cnt <= '0;
      else if (stable_cnt != 8'(SETTLE))
        stable_cnt <= stable_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q  <= '0;
      dots_q    <= '0;
      valid_q   <= '0;
      mask      <= '0;
      age       <= '0;
      frame_q   <= 1'b0;
      bad_seg_q <= 1'b0;
      bad_sel_q <= 1'b0;
    end else begin
      frame_q   <= frame_fire;
      bad_seg_q <= 1'b0;
      bad_sel_q <= 1'b0;
      if (capture && sel_info.kind == SEL_MULTI) begin
        bad_sel_q <= 1'b1;
      end else if (capture && sel_info.kind == SEL_ONE) begin
        if (match) begin
          digits_q[{sel_info.index, 2'b00} +: 4] <= nibble;
          dots_q[sel_info.index]                 <= ~seg_sync[7];
          valid_q[sel_info.index]                <= 1'b1;
          if (frame_fire)
            mask <= '0;
          else
            mask[sel_info.index] <= 1'b1;
        end else begin
          bad_seg_q               <= 1'b1;
          valid_q[sel_info.index] <= 1'b0;
        end
      end
      if (frame_fire)
        age <= '0;
      else if (age != AW'(STALE))
        age <= age + 1'b1;
      // Staleness wins over a capture landing on the same edge.
      if (!frame_fire && age == AW'(STALE - 1)) begin
        valid_q <= '0;
        mask    <= '0;
      end
    end
  end

  assign bus.digits     = digits_q;
  assign bus.dots       = dots_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_q;
  assign bus.bad_seg    = bad_seg_q;
  assign bus.bad_sel    = bad_sel_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench: drives multiplexed sweeps, predicts pulses into a scoreboard queue
// and compares them against what the capture block reports.
module tb_seven_seg_capture;

  localparam int SETTLE = 16;
  localparam int STALE  = 1000;

  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_SEG   = 2'd2;
  localparam logic [1:0] K_SEL   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  valid;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seven_seg_capture_if ifc ();

  seven_seg_capture #(.SETTLE(SETTLE), .STALE(STALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Independent active-high gfedcba glyph table for 0-F.
  logic [6:0] tb_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          frame_cyc = 0;
  int          overlap = 0;
  logic [15:0] m_digits = '0;
  logic [3:0]  m_dots = '0, m_valid = '0, m_mask = '0;
  logic [3:0]  last_sel = 4'hF;
  logic [7:0]  last_seg = 8'hFF;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.frame_done) begin
        obs_q.push_back({K_FRAME, ifc.digits, ifc.dots, ifc.valid});
        frame_cyc <= cyc;
      end
      if (ifc.bad_seg) obs_q.push_back({K_SEG, ifc.digits, ifc.dots, ifc.valid});
      if (ifc.bad_sel) obs_q.push_back({K_SEL, ifc.digits, ifc.dots, ifc.valid});
      if (ifc.frame_done && ifc.bad_seg) overlap <= overlap + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] seg_of(input int n, input logic dot);
    return {~dot, ~tb_glyph[n]};
  endfunction

  task automatic model_capture(input logic [3:0] sel, input logic [7:0] seg);
    int zeros, idx, nib;
    zeros = 0; idx = 0; nib = -1;
    for (int i = 0; i < 4; i++) if (!sel[i]) begin zeros++; idx = i; end
    if (zeros > 1) begin
      exp_q.push_back({K_SEL, m_digits, m_dots, m_valid});
    end else if (zeros == 1) begin
      for (int n = 0; n < 16; n++) if (~seg[6:0] == tb_glyph[n]) nib = n;
      if (nib < 0) begin
        m_valid[idx] = 1'b0;
        exp_q.push_back({K_SEG, m_digits, m_dots, m_valid});
      end else begin
        m_digits[4*idx +: 4] = nib[3:0];
        m_dots[idx]  = ~seg[7];
        m_valid[idx] = 1'b1;
        m_mask[idx]  = 1'b1;
        if (idx == 0 && m_mask[3:1] == 3'b111) begin
          exp_q.push_back({K_FRAME, m_digits, m_dots, m_valid});
          m_mask = '0;
        end
      end
    end
  endtask

  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int cycles);
    @(negedge clk);
    ifc.io_sel = sel;
    ifc.io_seg = seg;
    if (cycles >= SETTLE && {sel, seg} != {last_sel, last_seg}) model_capture(sel, seg);
    last_sel = sel;
    last_seg = seg;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic sweep(input int d3, input int d2, input int d1, input int d0, input logic dot0);
    hold(4'b0111, seg_of(d3, 1'b0), 64);
    hold(4'b1011, seg_of(d2, 1'b0), 64);
    hold(4'b1101, seg_of(d1, 1'b0), 64);
    hold(4'b1110, seg_of(d0, dot0), 64);
  endtask

  task automatic test_reset;
    ifc.io_sel = 4'hF;
    ifc.io_seg = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifc.digits !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_digits: got %h want 0000", ifc.digits); end
    n_cmp++; if (ifc.dots !== 4'h0) begin n_err++; $display("[TB] FAIL reset_dots: got %b want 0000", ifc.dots); end
    n_cmp++; if (ifc.valid !== 4'h0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0000", ifc.valid); end
    n_cmp++; if ({ifc.frame_done, ifc.bad_seg, ifc.bad_sel} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_pulses: got %b want 000", {ifc.frame_done, ifc.bad_seg, ifc.bad_sel}); end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_latency;
    ev_t e, o;
    @(negedge clk);
    ifc.io_sel = 4'b0111;
    ifc.io_seg = seg_of(13, 1'b0);
    model_capture(4'b0111, seg_of(13, 1'b0));
    last_sel = 4'b0111;
    last_seg = seg_of(13, 1'b0);
    repeat (SETTLE + 1) @(posedge clk);
    #1;
    n_cmp++; if (ifc.digits[15:12] !== 4'h0) begin n_err++; $display("[TB] FAIL latency_early: got %h want 0 after %0d edges", ifc.digits[15:12], SETTLE + 1); end
    @(posedge clk);
    #1;
    n_cmp++; if ({ifc.digits[15:12], ifc.valid[3]} !== {4'hD, 1'b1}) begin n_err++; $display("[TB] FAIL latency_capture: got %h/%b want d/1 after %0d edges", ifc.digits[15:12], ifc.valid[3], SETTLE + 2); end
    repeat (64 - SETTLE - 2) @(posedge clk);
    hold(4'b1011, seg_of(14, 1'b0), 64);
    hold(4'b1101, seg_of(10, 1'b0), 64);
    hold(4'b1110, seg_of(13, 1'b0), 64);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL latency_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL latency_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_sweep;
    ev_t e, o;
    sweep(13, 14, 10, 13, 1'b0);
    sweep(13, 14, 10, 13, 1'b0);
    #1;
    n_cmp++; if ({ifc.digits, ifc.valid, ifc.dots} !== {16'hDEAD, 4'hF, 4'h0}) begin n_err++; $display("[TB] FAIL sweep_state: got %h/%b/%b want DEAD/1111/0000", ifc.digits, ifc.valid, ifc.dots); end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL sweep_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL sweep_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_switch;
    ev_t e, o;
    hold(4'b0111, seg_of(13, 1'b0), 64);
    hold(4'b1011, seg_of(14, 1'b0), 64);
    sweep(11, 14, 14, 15, 1'b0);
    #1;
    n_cmp++; if (ifc.digits !== 16'hBEEF) begin n_err++; $display("[TB] FAIL switch_digits: got %h want BEEF", ifc.digits); end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL switch_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL switch_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_glitch;
    hold(4'b1011, 8'h00, 10);
    hold(4'b1111, 8'hFF, 20);
    #1;
    n_cmp++; if ({ifc.digits, ifc.dots, ifc.valid} !== {m_digits, m_dots, m_valid}) begin n_err++; $display("[TB] FAIL glitch_state: got %h/%b/%b want %h/%b/%b", ifc.digits, ifc.dots, ifc.valid, m_digits, m_dots, m_valid); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("[TB] FAIL glitch_pulses: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bad_seg;
    ev_t e, o;
    hold(4'b1011, 8'hFF, 20);
    #1;
    n_cmp++; if ({ifc.valid, ifc.digits[11:8]} !== {4'b1011, 4'hE}) begin n_err++; $display("[TB] FAIL bad_seg_state: got %b/%h want 1011/e", ifc.valid, ifc.digits[11:8]); end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL bad_seg_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL bad_seg_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_bad_sel;
    ev_t e, o;
    hold(4'b0011, seg_of(1, 1'b0), 20);
    #1;
    n_cmp++; if ({ifc.valid, ifc.digits} !== {4'b1011, 16'hBEEF}) begin n_err++; $display("[TB] FAIL bad_sel_state: got %b/%h want 1011/BEEF", ifc.valid, ifc.digits); end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL bad_sel_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL bad_sel_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_stale;
    ev_t e, o;
    int  waited;
    sweep(13, 14, 10, 13, 1'b0);
    hold(4'b1111, 8'hFF, 1);
    waited = 0;
    while (ifc.valid !== 4'b0000 && waited < 2 * STALE) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (ifc.valid !== 4'b0000) begin n_err++; $display("[TB] FAIL stale_valid: got %b want 0000 within %0d cycles", ifc.valid, 2 * STALE); end
    n_cmp++; if (cyc - frame_cyc !== STALE) begin n_err++; $display("[TB] FAIL stale_delay: got %0d cycles want %0d", cyc - frame_cyc, STALE); end
    n_cmp++; if (ifc.digits !== 16'hDEAD) begin n_err++; $display("[TB] FAIL stale_digits: got %h want DEAD", ifc.digits); end
    m_valid = '0;
    m_mask  = '0;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL stale_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL stale_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    hold(4'b0111, seg_of(11, 1'b0), 64);
    hold(4'b1011, seg_of(14, 1'b0), 64);
    hold(4'b1101, seg_of(14, 1'b0), 30);
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++; if ({ifc.digits, ifc.dots, ifc.valid, ifc.frame_done, ifc.bad_seg, ifc.bad_sel} !== '0) begin n_err++; $display("[TB] FAIL reset_mid_clear: got %h/%b/%b want all zero", ifc.digits, ifc.dots, ifc.valid); end
    exp_q.delete();
    m_digits = '0; m_dots = '0; m_valid = '0; m_mask = '0;
    last_sel = 4'hF; last_seg = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    hold(4'b1101, seg_of(14, 1'b0), 64);
    hold(4'b1110, seg_of(15, 1'b1), 64);
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("[TB] FAIL reset_mid_partial: got %0d events want 0", obs_q.size()); end
    sweep(11, 14, 14, 15, 1'b1);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_err++; $display("[TB] FAIL reset_mid_events: pending expected %0d observed %0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("[TB] FAIL reset_mid_event: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_exclusive;
    n_cmp++; if (overlap !== 0) begin n_err++; $display("[TB] FAIL pulse_overlap: got %0d cycles want 0", overlap); end
  endtask

  initial begin
    ifc.io_sel = 4'hF;
    ifc.io_seg = 8'hFF;
    test_reset();
    test_latency();
    test_sweep();
    test_switch();
    test_glitch();
    test_bad_seg();
    test_bad_sel();
    test_stale();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter SETTLE, default 16: consecutive stable clk cycles required before a sel/seg observation is captured (range 2..255).
REQ-002 Parameter STALE, default 1048576: clk cycles without a completed frame before all digits are invalidated.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 io_sel  input  4  multiplexed digit select, active-low one-cold; bit 3 = leftmost digit.
REQ-006 io_seg  input  8  segment bus, active-low, bit order .gfedcba (bit 7 = dot).
REQ-007 digits  output  16  recovered hex values; digits[4i+3:4i] = digit i.
REQ-008 dots  output  4  recovered decimal points, 1 = lit.
REQ-009 valid  output  4  per-digit: holds a decoded value from the current frame period.
REQ-010 frame_done  output  1  one-cycle pulse when a full 3-2-1-0 sweep has been captured.
REQ-011 bad_seg  output  1  one-cycle pulse: stable pattern on a selected digit matches no hex glyph.
REQ-012 bad_sel  output  1  one-cycle pulse: stable io_sel has more than one bit low.

Function
REQ-013 io_sel and io_seg SHALL pass through a 2-flop synchronizer; flops reset to all-ones (inactive).
REQ-014 Stability counter SHALL clear when synchronized {sel,seg} differs from the previous cycle, else increment, saturating at SETTLE.
REQ-015 Capture SHALL fire exactly once per stable period, on the cycle the counter reaches SETTLE-1; outputs update on clk edge SETTLE+2 after the first edge sampling the new value.
REQ-016 Observations stable fewer than SETTLE cycles SHALL cause no output change.
REQ-017 Sel 1110/1101/1011/0111 SHALL map to digit index 0/1/2/3; sel 1111 (blanking) SHALL be ignored.
REQ-018 Sel with two or more zeros SHALL pulse bad_sel and change no other output.
REQ-019 Decode of ~seg[6:0] SHALL use the glyph table 0-9, A, b, C, d, E, F; a match writes the nibble to digits, ~seg[7] to dots, and sets valid for that index.
REQ-020 A non-matching pattern (including all-off) SHALL pulse bad_seg and clear valid for that index; digits/dots are retained.
REQ-021 A 4-bit capture mask SHALL record successful captures; frame_done pulses when digit 0 is captured with mask bits 3..1 set, and the mask then clears.
REQ-022 Captures in any other order SHALL only set mask bits; no frame_done.
REQ-023 Age counter SHALL clear on frame_done, else increment; on reaching STALE it clears valid to 0000 and the mask, and holds until the next frame_done.
REQ-024 frame_done and bad_seg SHALL never assert in the same cycle.

Reset
REQ-025 On rst: digits=0000h, dots=0000, valid=0000, frame_done=0, bad_seg=0, bad_sel=0, counters and mask=0.
REQ-026 Reset asserted mid-frame SHALL discard partial captures; the first frame_done after release requires a full new sweep.

Structure
REQ-027 Shared package SHALL hold glyph constants SEG_0..SEG_F and SEG_DOT (active-low .gfedcba), also used by the display driver.
REQ-028 Combinational glyph-to-nibble lookup SHALL be the sub-module seven_seg_decode (outputs nibble and match).

Verification
REQ-029 Drive sweep d,E,A,d on digits 3..0, 64 cycles each, SETTLE=16 -> digits=DEADh, valid=1111, one frame_done per sweep.
REQ-030 Switch to b,E,E,F mid-sweep -> digits=BEEFh after the first full sweep; no frame_done for the partial sweep.
REQ-031 Inject 10-cycle glitch seg=00h on digit 2 -> no output change, no bad_seg.
REQ-032 Hold seg=FFh on sel=1011 for 20 cycles -> one bad_seg pulse, valid[2]=0, digits[11:8] unchanged.
REQ-033 sel=0011 for 20 cycles -> one bad_sel pulse; stop sweeping with STALE=1000 -> valid=0000 exactly 1000 cycles after the last frame_done.
REQ-034 Assert rst during digit 1 of a sweep -> all outputs zero immediately; frame_done only after the next complete 3-2-1-0 sweep.
